stopwatch_controller: RTL and testbench

//  Sequences the stopwatch time base. Divides clk into a 10 ms tick, runs cascaded

---
 rtl/stopwatch_controller_pkg.sv | 22 ++
 rtl/stopwatch_controller_time_counter.sv | 60 ++++++
 rtl/stopwatch_controller.sv | 126 ++++++++++++
 tb/tb_stopwatch_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_controller_pkg.sv
// Shared types and limits for the stopwatch time base.
package stopwatch_controller_pkg;

  localparam int unsigned WIDTH   = 7;
  localparam int unsigned CS_MAX  = 99;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] min;
    logic [WIDTH-1:0] sec;
    logic [WIDTH-1:0] cs;
  } time_t;

endpackage

// File: rtl/stopwatch_controller_time_counter.sv
// Cascaded centisecond/second/minute counter; holds at 99:59.99 and flags at_max.
module stopwatch_time_counter
  import stopwatch_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             tick,
  output logic [WIDTH-1:0] cs,
  output logic [WIDTH-1:0] sec,
  output logic [WIDTH-1:0] min,
  output logic             at_max
);

  logic [WIDTH-1:0] cs_q, sec_q, min_q;
  logic [WIDTH-1:0] cs_d, sec_d, min_d;

  assign at_max = (cs_q == WIDTH'(CS_MAX)) && (sec_q == WIDTH'(SEC_MAX)) &&
                  (min_q == WIDTH'(MIN_MAX));

  always_comb begin
    cs_d  = cs_q;
    sec_d = sec_q;
    min_d = min_q;
    if (clr) begin
      cs_d  = '0;
      sec_d = '0;
      min_d = '0;
    end else if (tick && !at_max) begin
      if (cs_q == WIDTH'(CS_MAX)) begin
        cs_d = '0;
        if (sec_q == WIDTH'(SEC_MAX)) begin
          sec_d = '0;
          min_d = min_q + WIDTH'(1);
        end else begin
          sec_d = sec_q + WIDTH'(1);
        end
      end else begin
        cs_d = cs_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q  <= '0;
      sec_q <= '0;
      min_q <= '0;
    end else begin
      cs_q  <= cs_d;
      sec_q <= sec_d;
      min_q <= min_d;
    end
  end

  assign cs  = cs_q;
  assign sec = sec_q;
  assign min = min_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: button edge detect, run/lap/stop FSM, 10 ms prescaler,
// lap freeze register and registered display mux.
module stopwatch_controller
  import stopwatch_controller_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 500000,
  parameter logic        LZ_SUPPRESS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic [6:0] sms,
  output logic [6:0] s,
  output logic [6:0] m,
  output logic       lz,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic          ss_q, lap_q, clr_q;
  logic          ev_ss, ev_lap, ev_clr;
  logic [PW-1:0] presc_q;
  logic          counting, tick, ovf_hit, lap_load, ovf_q;
  logic [6:0]    cnt_cs, cnt_sec, cnt_min;
  logic          at_max;
  time_t         live, lap_reg, shown;

  assign ev_clr   = btn_clr & ~clr_q;
  assign ev_ss    = btn_ss  & ~ss_q;
  assign ev_lap   = btn_lap & ~lap_q;
  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc_q == PRESC_LAST);
  assign ovf_hit  = tick && at_max;
  assign live     = {cnt_min, cnt_sec, cnt_cs};
  assign shown    = (state_q == LAP) ? lap_reg : live;
  assign ovf      = ovf_q;

  stopwatch_time_counter u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (ev_clr),
    .tick   (tick),
    .cs     (cnt_cs),
    .sec    (cnt_sec),
    .min    (cnt_min),
    .at_max (at_max)
  );

  always_comb begin
    state_d  = state_q;
    lap_load = 1'b0;
    if (ev_clr) begin
      state_d = IDLE;
    end else if (ovf_hit) begin
      state_d = STOP;
    end else begin
      unique case (state_q)
        IDLE: if (ev_ss) state_d = RUN;
        RUN: begin
          if (ev_ss) begin
            state_d = STOP;
          end else if (ev_lap) begin
            state_d  = LAP;
            lap_load = 1'b1;
          end
        end
        LAP: begin
          if (ev_ss)       state_d = STOP;
          else if (ev_lap) state_d = RUN;
        end
        STOP: if (ev_ss && !ovf_q) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      // History follows the buttons during reset so a button held through
      // reset release is not mistaken for a fresh press.
      ss_q       <= btn_ss;
      lap_q      <= btn_lap;
      clr_q      <= btn_clr;
      presc_q    <= '0;
      lap_reg    <= '0;
      ovf_q      <= 1'b0;
      sms        <= '0;
      s          <= '0;
      m          <= '0;
      lz         <= LZ_SUPPRESS;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= btn_ss;
      lap_q   <= btn_lap;
      clr_q   <= btn_clr;

      if (ev_clr)        presc_q <= '0;
      else if (tick)     presc_q <= '0;
      else if (counting) presc_q <= presc_q + PW'(1);

      if (ev_clr)        lap_reg <= '0;
      else if (lap_load) lap_reg <= live;

      if (ev_clr)       ovf_q <= 1'b0;
      else if (ovf_hit) ovf_q <= 1'b1;

      sms        <= shown.cs;
      s          <= shown.sec;
      m          <= shown.min;
      lz         <= LZ_SUPPRESS & (shown.min == '0);
      running    <= (state_d == RUN) || (state_d == LAP);
      lap_active <= (state_d == LAP);
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench: directed scenarios plus random button traffic, compared
// every cycle against a centisecond-count model of the stopwatch.
module tb_stopwatch_controller;

  localparam int TD   = 4;
  localparam int MAXV = 99 * 6000 + 59 * 100 + 99;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic [6:0] sms, s, m;
  logic       lz, running, lap_active, ovf;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  bit         pre_req = 1'b0;
  int         pre_val = 0;
  logic [6:0] pre_cs, pre_sec, pre_min;

  typedef struct {
    bit run, lapm, ovf;
    int live, lapv, phase;
    int dsms, ds, dm;
    bit dlz, drun, dlap;
    bit hss, hlap, hclr;
  } model_t;

  model_t mdl;

  stopwatch_controller #(.TICK_DIV(TD), .LZ_SUPPRESS(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_ss     (btn_ss),
    .btn_lap    (btn_lap),
    .btn_clr    (btn_clr),
    .sms        (sms),
    .s          (s),
    .m          (m),
    .lz         (lz),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // One clock of the stopwatch, in terms of a total centisecond count.
  function automatic model_t step(model_t c, bit r, bit ss, bit lp, bit cl, bit pre, int pv);
    model_t n;
    bit e_ss, e_lap, e_clr, tk;
    int shown;
    if (pre) c.live = pv;
    n = c;
    n.hss = ss; n.hlap = lp; n.hclr = cl;
    if (r) begin
      n.run = 0; n.lapm = 0; n.ovf = 0;
      n.live = 0; n.lapv = 0; n.phase = 0;
      n.dsms = 0; n.ds = 0; n.dm = 0; n.dlz = 1; n.drun = 0; n.dlap = 0;
      return n;
    end
    shown  = c.lapm ? c.lapv : c.live;
    n.dsms = shown % 100;
    n.ds   = (shown / 100) % 60;
    n.dm   = shown / 6000;
    n.dlz  = (n.dm == 0);
    e_clr = cl && !c.hclr;
    e_ss  = ss && !c.hss;
    e_lap = lp && !c.hlap;
    tk    = c.run && (c.phase == TD - 1);
    if (e_clr) begin
      n.run = 0; n.lapm = 0; n.ovf = 0; n.live = 0; n.lapv = 0; n.phase = 0;
    end else begin
      if (c.run) n.phase = tk ? 0 : c.phase + 1;
      if (tk && c.live == MAXV) begin
        n.ovf = 1; n.run = 0; n.lapm = 0;
      end else begin
        if (tk) n.live = c.live + 1;
        if (e_ss) begin
          if (c.run) begin
            n.run = 0; n.lapm = 0;
          end else if (!c.ovf) begin
            n.run = 1;
          end
        end else if (e_lap && c.run) begin
          if (c.lapm) n.lapm = 0;
          else begin
            n.lapm = 1; n.lapv = c.live;
          end
        end
      end
    end
    n.drun = n.run;
    n.dlap = n.lapm;
    return n;
  endfunction

  always @(posedge clk) mdl <= step(mdl, reset, btn_ss, btn_lap, btn_clr, pre_req, pre_val);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("sms", 32'(sms), mdl.dsms);
      check("s", 32'(s), mdl.ds);
      check("m", 32'(m), mdl.dm);
      check("lz", 32'(lz), 32'(mdl.dlz));
      check("running", 32'(running), 32'(mdl.drun));
      check("lap_active", 32'(lap_active), 32'(mdl.dlap));
      check("ovf", 32'(ovf), 32'(mdl.ovf));
    end
  end

  task automatic press(input int which);
    case (which)
      0: btn_ss = 1'b1;
      1: btn_lap = 1'b1;
      default: btn_clr = 1'b1;
    endcase
    @(negedge clk);
    btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
  endtask

  task automatic wait_model(input int live, input int phase, input bit want_ovf, input string name);
    int n = 0;
    while (!(want_ovf ? mdl.ovf : (mdl.live == live && (phase < 0 || mdl.phase == phase)))
           && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 6000) begin
      errors++;
      $display("FAIL %s: wait timed out, live %0d expected %0d", name, mdl.live, live);
    end
  endtask

  task automatic preload(input int v);
    pre_cs  = 7'(v % 100);
    pre_sec = 7'((v / 100) % 60);
    pre_min = 7'(v / 6000);
    pre_val = v;
    pre_req = 1'b1;
    force dut.u_cnt.cs_q  = pre_cs;
    force dut.u_cnt.sec_q = pre_sec;
    force dut.u_cnt.min_q = pre_min;
    @(negedge clk);
    release dut.u_cnt.cs_q;
    release dut.u_cnt.sec_q;
    release dut.u_cnt.min_q;
    pre_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_sms", 32'(sms), 0);
    check("rst_lz", 32'(lz), 1);
    check("rst_running", 32'(running), 0);
    check("rst_lap_active", 32'(lap_active), 0);
    check("rst_ovf", 32'(ovf), 0);
    reset = 1'b0;

    // 100 ticks after start -> 00:01.00
    press(0);
    repeat (401) @(negedge clk);
    check("t1_sms", 32'(sms), 0);
    check("t1_s", 32'(s), 1);
    check("t1_m", 32'(m), 0);
    check("t1_lz", 32'(lz), 1);
    check("t1_running", 32'(running), 1);

    // lap freeze at 05.20, release after 8 ticks
    wait_model(520, 0, 1'b0, "t2_wait520");
    press(1);
    repeat (20) @(negedge clk);
    check("t2_frozen_sms", 32'(sms), 20);
    check("t2_frozen_s", 32'(s), 5);
    check("t2_lap_active", 32'(lap_active), 1);
    check("t2_running", 32'(running), 1);
    wait_model(528, 0, 1'b0, "t2_wait528");
    press(1);
    @(negedge clk);
    check("t2_live_sms", 32'(sms), 28);
    check("t2_live_s", 32'(s), 5);
    check("t2_lap_off", 32'(lap_active), 0);

    // stop at 07 mid-phase, resume keeps prescaler phase
    press(2);
    press(0);
    wait_model(7, 1, 1'b0, "t3_wait7");
    press(0);
    check("t3_stopped", 32'(running), 0);
    repeat (40) @(negedge clk);
    check("t3_hold_sms", 32'(sms), 7);
    press(0);
    @(negedge clk);
    @(negedge clk);
    check("t3_before_tick", 32'(sms), 7);
    @(negedge clk);
    check("t3_after_tick", 32'(sms), 8);

    // saturation at 99:59.99
    press(2);
    preload(MAXV - 1);
    press(0);
    wait_model(0, 0, 1'b1, "t4_wait_ovf");
    repeat (2) @(negedge clk);
    check("t4_ovf", 32'(ovf), 1);
    check("t4_running", 32'(running), 0);
    check("t4_sms", 32'(sms), 99);
    check("t4_s", 32'(s), 59);
    check("t4_m", 32'(m), 99);
    check("t4_lz", 32'(lz), 0);
    press(0);
    repeat (5) @(negedge clk);
    check("t4_ss_ignored", 32'(running), 0);
    check("t4_still_sat", 32'(sms), 99);
    press(2);
    check("t4_clr_ovf", 32'(ovf), 0);
    @(negedge clk);
    check("t4_clr_sms", 32'(sms), 0);
    check("t4_clr_m", 32'(m), 0);
    check("t4_clr_lz", 32'(lz), 1);

    // clr beats ss in the same cycle
    press(0);
    repeat (30) @(negedge clk);
    btn_ss = 1'b1; btn_clr = 1'b1;
    @(negedge clk);
    btn_ss = 1'b0; btn_clr = 1'b0;
    check("t5_running", 32'(running), 0);
    @(negedge clk);
    check("t5_sms", 32'(sms), 0);
    check("t5_s", 32'(s), 0);

    // reset mid-run at 01:23.45, ss held through reset release
    preload(8344);
    press(0);
    wait_model(8345, -1, 1'b0, "t6_wait8345");
    reset = 1'b1; btn_ss = 1'b1;
    @(negedge clk);
    check("t6_sms", 32'(sms), 0);
    check("t6_s", 32'(s), 0);
    check("t6_m", 32'(m), 0);
    check("t6_lz", 32'(lz), 1);
    check("t6_running", 32'(running), 0);
    check("t6_ovf", 32'(ovf), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_held_no_event", 32'(running), 0);
    btn_ss = 1'b0;
    @(negedge clk);
    press(0);
    check("t6_repress", 32'(running), 1);

    // random button traffic, with one jump near saturation
    for (int i = 0; i < 4000; i++) begin
      if (i == 1500) preload(MAXV - 40);
      @(negedge clk);
      if ($urandom_range(0, 29) == 0)  btn_ss  = ~btn_ss;
      if ($urandom_range(0, 24) == 0)  btn_lap = ~btn_lap;
      if ($urandom_range(0, 399) == 0) btn_clr = ~btn_clr;
      reset = ($urandom_range(0, 1999) == 0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
